result_bram_reader: RTL and testbench

RESULT_BRAM_READER -- requirements
Module: result_bram_reader

---
 rtl/gemm_result_pkg.sv | 16 +
 rtl/result_bram_reader.sv | 110 +++++++++++
 tb/tb_result_bram_reader.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/gemm_result_pkg.sv
// Shared defaults and state encoding for the GEMM result BRAM read-out path.
package gemm_result_pkg;

    localparam int BRAM_ADDR_WIDTH = 9;
    localparam int BRAM_DATA_WIDTH = 256;
    localparam int FP16_PER_LINE   = 16;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_FETCH,
        RD_WAIT,
        RD_STREAM,
        RD_DONE
    } rd_state_e;

endpackage

// File: rtl/result_bram_reader.sv
// Reads FP16 results out of an external BRAM one line at a time and streams
// them lane by lane over a valid/ready handshake.
module result_bram_reader
    import gemm_result_pkg::*;
#(
    parameter int BRAM_ADDR_WIDTH = gemm_result_pkg::BRAM_ADDR_WIDTH,
    parameter int BRAM_DATA_WIDTH = gemm_result_pkg::BRAM_DATA_WIDTH,
    parameter int FP16_PER_LINE   = gemm_result_pkg::FP16_PER_LINE
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_start,
    input  logic                       i_clear,
    input  logic [BRAM_ADDR_WIDTH-1:0] i_base_addr,
    input  logic [15:0]                i_num_values,
    output logic                       o_bram_rd_en,
    output logic [BRAM_ADDR_WIDTH-1:0] o_bram_rd_addr,
    input  logic [BRAM_DATA_WIDTH-1:0] i_bram_rd_data,
    output logic [15:0]                o_fp16_data,
    output logic                       o_fp16_valid,
    input  logic                       i_fp16_ready,
    output logic                       o_fp16_last,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [31:0]                o_value_count
);

    localparam int LANE_W = (FP16_PER_LINE > 1) ? $clog2(FP16_PER_LINE) : 1;
    localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(FP16_PER_LINE - 1);

    rd_state_e                  state_q;
    logic [BRAM_ADDR_WIDTH-1:0] addr_q;
    logic [BRAM_DATA_WIDTH-1:0] line_q;
    logic [LANE_W-1:0]          lane_q;
    logic [15:0]                rem_q;
    logic [31:0]                count_q;
    logic [15:0]                lane_data_d;
    logic                       xfer_d;

    always_comb begin
        lane_data_d = '0;
        for (int i = 0; i < FP16_PER_LINE; i++) begin
            if (lane_q == LANE_W'(i)) lane_data_d = line_q[i*16 +: 16];
        end
    end

    assign xfer_d = (state_q == RD_STREAM) && i_fp16_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= RD_IDLE;
            addr_q  <= '0;
            line_q  <= '0;
            lane_q  <= '0;
            rem_q   <= '0;
            count_q <= '0;
        end else if (i_clear) begin
            // Abort without capturing any in-flight line and without a done pulse.
            state_q <= RD_IDLE;
            lane_q  <= '0;
            rem_q   <= '0;
            count_q <= '0;
        end else begin
            case (state_q)
                RD_IDLE: begin
                    if (i_start) begin
                        addr_q  <= i_base_addr;
                        rem_q   <= i_num_values;
                        lane_q  <= '0;
                        state_q <= (i_num_values == 16'd0) ? RD_DONE : RD_FETCH;
                    end
                end
                RD_FETCH: state_q <= RD_WAIT;
                RD_WAIT: begin
                    line_q  <= i_bram_rd_data;
                    lane_q  <= '0;
                    state_q <= RD_STREAM;
                end
                RD_STREAM: begin
                    if (xfer_d) begin
                        count_q <= count_q + 32'd1;
                        rem_q   <= rem_q - 16'd1;
                        if (rem_q == 16'd1) begin
                            state_q <= RD_DONE;
                        end else if (lane_q == LANE_MAX) begin
                            // Address register is exactly BRAM_ADDR_WIDTH wide, so it wraps.
                            addr_q  <= addr_q + BRAM_ADDR_WIDTH'(1);
                            lane_q  <= '0;
                            state_q <= RD_FETCH;
                        end else begin
                            lane_q  <= lane_q + LANE_W'(1);
                        end
                    end
                end
                RD_DONE: state_q <= RD_IDLE;
                default: state_q <= RD_IDLE;
            endcase
        end
    end

    assign o_bram_rd_en   = (state_q == RD_FETCH);
    assign o_bram_rd_addr = addr_q;
    assign o_fp16_valid   = (state_q == RD_STREAM);
    assign o_fp16_data    = lane_data_d;
    assign o_fp16_last    = (state_q == RD_STREAM) && (rem_q == 16'd1);
    assign o_busy         = (state_q != RD_IDLE);
    assign o_done         = (state_q == RD_DONE);
    assign o_value_count  = count_q;

endmodule

// File: tb/tb_result_bram_reader.sv
// Scoreboard bench for result_bram_reader: directed read-outs with a BRAM model.
module tb_result_bram_reader;

    localparam int AW = 9;
    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          rst, start, clear, ready;
    logic [AW-1:0] base;
    logic [15:0]   num;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [15:0]   fp16_data;
    logic          fp16_valid, fp16_last, busy, done;
    logic [31:0]   value_count;

    always #5 clk = ~clk;

    result_bram_reader dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_clear(clear),
        .i_base_addr(base), .i_num_values(num),
        .o_bram_rd_en(rd_en), .o_bram_rd_addr(rd_addr), .i_bram_rd_data(rd_data),
        .o_fp16_data(fp16_data), .o_fp16_valid(fp16_valid), .i_fp16_ready(ready),
        .o_fp16_last(fp16_last), .o_busy(busy), .o_done(done),
        .o_value_count(value_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // BRAM model: line n lane k holds {n[7:0], k[7:0]}, one-cycle read latency.
    function automatic logic [DW-1:0] mk_line(input logic [AW-1:0] a);
        logic [DW-1:0] l;
        logic [7:0] kk;
        l = '0;
        for (int k = 0; k < 16; k++) begin
            kk = 8'(k);
            l[k*16 +: 16] = {a[7:0], kk};
        end
        return l;
    endfunction

    always @(posedge clk) if (rd_en) rd_data <= mk_line(rd_addr);

    logic [16:0]   exp_q[$];
    logic [AW-1:0] rd_log[$];
    int            done_cnt = 0;
    int            xfers    = 0;
    logic          stall_prev = 1'b0;
    logic [15:0]   stall_data = '0;
    logic          rd_prev = 1'b0;
    bit            rand_rdy = 1'b0;

    // Monitor: observes at negedge what the next rising edge will commit.
    always @(negedge clk) begin
        logic [16:0] e;
        if (rd_en) begin
            rd_log.push_back(rd_addr);
            chk("rd_en single cycle", {31'd0, rd_prev}, 32'd0);
        end
        rd_prev = rd_en;
        if (done) done_cnt++;
        if (fp16_valid && stall_prev)
            chk("data stable while stalled", {16'd0, fp16_data}, {16'd0, stall_data});
        if (fp16_valid && ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected transfer", {15'd0, fp16_last, fp16_data}, 32'h1_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("stream {last,data}", {15'd0, fp16_last, fp16_data}, {15'd0, e});
            end
            xfers++;
        end
        stall_prev = fp16_valid && !ready;
        stall_data = fp16_data;
    end

    task automatic push_seq(input int b, input int n);
        int ln, lane;
        logic [15:0] v;
        ln = b; lane = 0;
        for (int i = 0; i < n; i++) begin
            v = {8'(ln), 8'(lane)};
            exp_q.push_back({(i == n - 1), v});
            lane++;
            if (lane == 16) begin lane = 0; ln = (ln + 1) % 512; end
        end
    endtask

    task automatic start_rd(input int b, input int n);
        @(posedge clk); #1;
        start = 1'b1; base = AW'(b); num = 16'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int d0, n;
        d0 = done_cnt; n = 0;
        while (done_cnt == d0 && n < 3000) begin
            @(posedge clk); #1;
            if (rand_rdy) ready = 1'($urandom_range(0, 1));
            n++;
        end
        ready = 1'b1;
        chk({nm, " done seen"}, done_cnt - d0, 1);
        chk({nm, " idle after done"}, {31'd0, busy}, 32'd0);
        chk({nm, " scoreboard drained"}, exp_q.size(), 0);
    endtask

    task automatic chk_addrs(input string nm, input int a0, input int a1);
        chk({nm, " read count"}, rd_log.size(), 2);
        if (rd_log.size() == 2) begin
            chk({nm, " addr0"}, {23'd0, rd_log[0]}, a0);
            chk({nm, " addr1"}, {23'd0, rd_log[1]}, a1);
        end
        rd_log.delete();
    endtask

    initial begin
        int d0, x0, n;
        rst = 1'b1; start = 1'b0; clear = 1'b0; ready = 1'b1; base = '0; num = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset busy", {31'd0, busy}, 0);
        chk("reset valid", {31'd0, fp16_valid}, 0);
        chk("reset rd_en/addr", {22'd0, rd_en, rd_addr}, 0);
        chk("reset data/last", {15'd0, fp16_last, fp16_data}, 0);
        chk("reset count", value_count, 0);

        // Two full lines from address 0.
        push_seq(0, 32);
        start_rd(0, 32);
        wait_done("base0");
        chk_addrs("base0", 0, 1);
        chk("count after base0", value_count, 32);

        // Partial second line: lanes 4..15 of address 6 must not appear.
        push_seq(5, 20);
        start_rd(5, 20);
        wait_done("partial");
        chk_addrs("partial", 5, 6);
        chk("count after partial", value_count, 52);

        // Address wrap 511 -> 0.
        push_seq(511, 32);
        start_rd(511, 32);
        wait_done("wrap");
        chk_addrs("wrap", 511, 0);
        chk("count after wrap", value_count, 84);

        // Zero-length request goes straight to DONE.
        d0 = done_cnt;
        start_rd(0, 0);
        @(negedge clk);
        chk("num0 done pulse", {31'd0, done}, 1);
        chk("num0 busy in done", {31'd0, busy}, 1);
        @(negedge clk);
        chk("num0 done drops", {31'd0, done}, 0);
        chk("num0 idle", {31'd0, busy}, 0);
        chk("num0 one done", done_cnt - d0, 1);
        chk("num0 no reads", rd_log.size(), 0);
        chk("num0 count", value_count, 84);

        // Back-pressure with random ready.
        rand_rdy = 1'b1;
        push_seq(10, 48);
        start_rd(10, 48);
        wait_done("stall");
        rand_rdy = 1'b0;
        rd_log.delete();
        chk("count after stall", value_count, 132);

        // Clear after 7 transfers.
        push_seq(20, 40);
        d0 = done_cnt; x0 = xfers;
        start_rd(20, 40);
        n = 0;
        while ((xfers - x0) < 7 && n < 500) begin @(posedge clk); #1; n++; end
        chk("clear: transfers before clear", xfers - x0, 7);
        ready = 1'b0; clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; ready = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("clear busy", {31'd0, busy}, 0);
        chk("clear valid", {31'd0, fp16_valid}, 0);
        chk("clear count", value_count, 0);
        repeat (3) @(negedge clk);
        chk("clear no done", done_cnt - d0, 0);
        rd_log.delete();

        // Reset while FETCH is active.
        push_seq(0, 16);
        start_rd(0, 16);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rst fetch issued", rd_log.size(), 1);
        chk("rst busy", {31'd0, busy}, 0);
        chk("rst count", value_count, 0);
        chk("rst rd_en", {31'd0, rd_en}, 0);
        repeat (3) @(negedge clk);
        chk("rst no done", done_cnt - d0, 0);
        chk("rst still idle", {31'd0, busy}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
